// File: rtl/core_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*        : Funct3 size/sign encodings for loads and stores
//   lsu_state_t : transaction state (IDLE -> REQ -> DONE, or IDLE -> DONE on fault)
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ready bus.
//   MemReq/MemWE/MemAddr/MemWData/MemBE : request, driven by the master (LSU)
//   MemReady/MemRData                   : completion and word read data, driven by memory
interface load_store_unit_if #(
  parameter int D_WIDTH = 32
);

  logic               MemReq;
  logic               MemWE;
  logic [D_WIDTH-1:0] MemAddr;
  logic [D_WIDTH-1:0] MemWData;
  logic [3:0]         MemBE;
  logic               MemReady;
  logic [D_WIDTH-1:0] MemRData;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData, MemBE,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData, MemBE,
    output MemReady, MemRData
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane helper for the load/store unit.
//   funct3, addr     : access size/sign and low address bits
//   is_store         : selects the store legality rules
//   store_data       : raw store operand (RD2)
//   mem_rdata        : raw word read from memory
//   wdata, be        : lane-replicated store data and byte enables
//   load_data        : shifted and sign/zero-extended load result
//   misaligned       : access crosses its natural alignment
//   illegal          : Funct3 not valid for this access type
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] lane;

  always_comb begin
    lane       = mem_rdata >> {addr, 3'b000};
    wdata      = store_data;
    be         = 4'b1111;
    load_data  = mem_rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        wdata     = {4{store_data[7:0]}};
        be        = 4'b0001 << addr;
        load_data = {{24{lane[7]}}, lane[7:0]};
      end
      F3_H: begin
        wdata      = {2{store_data[15:0]}};
        be         = addr[1] ? 4'b1100 : 4'b0011;
        load_data  = {{16{lane[15]}}, lane[15:0]};
        misaligned = addr[0];
      end
      F3_W: begin
        misaligned = (addr != 2'b00);
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        be        = 4'b0001 << addr;
        load_data = {24'h0, lane[7:0]};
        illegal   = is_store;
      end
      F3_HU: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        load_data  = {16'h0, lane[15:0]};
        misaligned = addr[0];
        illegal    = is_store;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of a single-cycle core: runs one data-memory transaction per
// load/store instruction and holds the core with Stall until it completes.
//   CLK, RST_N          : clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite   : instruction is a load / store (store wins if both)
//   Funct3              : access size and sign
//   ALUResult, RD2      : byte address and store data from execute
//   mem                 : req/ready data-memory bus (master side)
//   ReadData            : formatted load result for writeback
//   Stall               : core must hold PC and register writes
//   AccessFault         : one-cycle pulse on misalignment, illegal Funct3 or timeout
module load_store_unit
  import core_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          Funct3,
  input  logic [D_WIDTH-1:0]  ALUResult,
  input  logic [D_WIDTH-1:0]  RD2,
  load_store_unit_if.master   mem,
  output logic [D_WIDTH-1:0]  ReadData,
  output logic                Stall,
  output logic                AccessFault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  logic [2:0]       f3_q;
  logic [1:0]       addr_q;
  logic [CNT_W-1:0] cnt;

  logic             access;
  logic             fault_now;
  logic [2:0]       sel_f3;
  logic [1:0]       sel_addr;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic [31:0]      load_data;
  logic             misaligned;
  logic             illegal;

  assign access = MemRead | MemWrite;

  // Request formatting uses the live instruction in IDLE; response formatting
  // in REQ uses the size and byte offset latched when the request was issued.
  assign sel_f3   = (state == IDLE) ? Funct3         : f3_q;
  assign sel_addr = (state == IDLE) ? ALUResult[1:0] : addr_q;

  lsu_align u_align (
    .funct3     (sel_f3),
    .addr       (sel_addr),
    .is_store   (MemWrite),
    .store_data (RD2),
    .mem_rdata  (mem.MemRData),
    .wdata      (wdata),
    .be         (be),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign fault_now = access && (misaligned || illegal);
  assign Stall     = ((state == IDLE) && access && !fault_now) || (state == REQ);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      f3_q         <= 3'b000;
      addr_q       <= 2'b00;
      cnt          <= '0;
      mem.MemReq   <= 1'b0;
      mem.MemWE    <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemWData <= '0;
      mem.MemBE    <= 4'b0000;
      ReadData     <= '0;
      AccessFault  <= 1'b0;
    end else begin
      AccessFault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (fault_now) begin
              AccessFault <= 1'b1;
              ReadData    <= '0;
              state       <= DONE;
            end else begin
              mem.MemReq   <= 1'b1;
              mem.MemWE    <= MemWrite;
              mem.MemAddr  <= {ALUResult[D_WIDTH-1:2], 2'b00};
              mem.MemBE    <= be;
              mem.MemWData <= wdata;
              f3_q         <= Funct3;
              addr_q       <= ALUResult[1:0];
              cnt          <= '0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.MemReady) begin
            mem.MemReq <= 1'b0;
            mem.MemWE  <= 1'b0;
            mem.MemBE  <= 4'b0000;
            // Stores leave the previous load result untouched.
            if (!mem.MemWE) begin
              ReadData <= load_data;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem.MemReq  <= 1'b0;
            mem.MemWE   <= 1'b0;
            mem.MemBE   <= 4'b0000;
            ReadData    <= '0;
            AccessFault <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // The core commits this instruction now; never start a new request here.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import core_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] RD2 = 32'h0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessFault;

  load_store_unit_if #(.D_WIDTH(32)) bus ();

  load_store_unit #(.D_WIDTH(32), .TIMEOUT(TO)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .RD2         (RD2),
    .mem         (bus),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .AccessFault (AccessFault)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations captured by the transaction drivers.
  logic        obs_stall_idle, obs_req_idle, obs_stall_req, obs_stable;
  int          obs_req_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_rd;
  logic [3:0]  obs_be, obs_be_done;
  logic        obs_we, obs_we_done, obs_stall_done, obs_req_done, obs_fault_done, obs_fault_after;

  // Drives one instruction starting just after a rising edge in IDLE; memory
  // answers after 'delay' REQ cycles. Returns just after the edge into IDLE.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rd2,
                         input logic [31:0] rdata, input int delay);
    #1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; RD2 = rd2;
    bus.MemReady = 1'b0; bus.MemRData = 32'h0;
    @(negedge CLK);
    obs_stall_idle = Stall; obs_req_idle = bus.MemReq;
    obs_req_cycles = 0; obs_stable = 1'b1; obs_stall_req = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      @(posedge CLK); #1;
      bus.MemReady = (i == delay);
      bus.MemRData = (i == delay) ? rdata : 32'h0;
      @(negedge CLK);
      if (bus.MemReq) obs_req_cycles++;
      if (!Stall) obs_stall_req = 1'b0;
      if (i == 0) begin
        obs_addr = bus.MemAddr; obs_be = bus.MemBE; obs_wdata = bus.MemWData; obs_we = bus.MemWE;
      end else if (bus.MemAddr !== obs_addr || bus.MemBE !== obs_be ||
                   bus.MemWData !== obs_wdata || bus.MemWE !== obs_we) begin
        obs_stable = 1'b0;
      end
    end
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0; bus.MemReady = 1'b0; bus.MemRData = 32'h0;
    @(negedge CLK);
    obs_rd = ReadData; obs_stall_done = Stall; obs_req_done = bus.MemReq;
    obs_be_done = bus.MemBE; obs_we_done = bus.MemWE; obs_fault_done = AccessFault;
    @(posedge CLK);
  endtask

  // Drives one faulting instruction (2-cycle path).
  task automatic run_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    #1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; RD2 = 32'hFFFF_FFFF;
    @(negedge CLK);
    obs_stall_idle = Stall; obs_req_idle = bus.MemReq;
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge CLK);
    obs_fault_done = AccessFault; obs_rd = ReadData; obs_req_done = bus.MemReq; obs_stall_done = Stall;
    @(posedge CLK); #1;
    obs_fault_after = AccessFault;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (bus.MemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", bus.MemReq); end
    n_cmp++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00000000", ReadData); end
    n_cmp++; if ({bus.MemWE, bus.MemBE, AccessFault, Stall} !== 7'b0) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=0000000", {bus.MemWE, bus.MemBE, AccessFault, Stall}); end
    n_cmp++; if (bus.MemAddr !== 32'h0 || bus.MemWData !== 32'h0) begin n_fail++; $display("FAIL rst_bus got=%h/%h exp=0/0", bus.MemAddr, bus.MemWData); end
    RST_N = 1'b1;
    @(posedge CLK);
  endtask

  task automatic test_lw();
    run_txn(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
    n_cmp++; if (obs_stall_idle !== 1'b1 || obs_req_idle !== 1'b0) begin n_fail++; $display("FAIL lw_idle stall/req got=%b%b exp=10", obs_stall_idle, obs_req_idle); end
    n_cmp++; if (obs_req_cycles != 1 || obs_stall_req !== 1'b1) begin n_fail++; $display("FAIL lw_req cycles/stall got=%0d/%b exp=1/1", obs_req_cycles, obs_stall_req); end
    n_cmp++; if (obs_addr !== 32'h104 || obs_be !== 4'b1111 || obs_we !== 1'b0) begin n_fail++; $display("FAIL lw_bus got=%h/%b/%b exp=00000104/1111/0", obs_addr, obs_be, obs_we); end
    n_cmp++; if (obs_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rd); end
    n_cmp++; if (obs_stall_done !== 1'b0 || obs_req_done !== 1'b0 || obs_be_done !== 4'b0 || obs_fault_done !== 1'b0) begin n_fail++; $display("FAIL lw_done stall/req/be/fault got=%b/%b/%b/%b exp=0/0/0000/0", obs_stall_done, obs_req_done, obs_be_done, obs_fault_done); end
  endtask

  task automatic test_load_ext();
    run_txn(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
    n_cmp++; if (obs_addr !== 32'h100 || obs_be !== 4'b1000) begin n_fail++; $display("FAIL lb_bus got=%h/%b exp=00000100/1000", obs_addr, obs_be); end
    n_cmp++; if (obs_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rd); end
    run_txn(1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
    n_cmp++; if (obs_rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rd); end
    // Halfword with a slow memory: request must hold steady while waiting.
    run_txn(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0, 32'h80FF_0000, 2);
    n_cmp++; if (obs_rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_rdata got=%h exp=ffff80ff", obs_rd); end
    n_cmp++; if (obs_req_cycles != 3 || obs_stable !== 1'b1 || obs_stall_req !== 1'b1) begin n_fail++; $display("FAIL lh_wait cycles/stable/stall got=%0d/%b/%b exp=3/1/1", obs_req_cycles, obs_stable, obs_stall_req); end
    n_cmp++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got=%b exp=1100", obs_be); end
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, F3_B, 32'h0000_0202, 32'h1234_5678, 32'h0, 0);
    n_cmp++; if (obs_wdata !== 32'h7878_7878 || obs_be !== 4'b0100 || obs_we !== 1'b1) begin n_fail++; $display("FAIL sb_bus got=%h/%b/%b exp=78787878/0100/1", obs_wdata, obs_be, obs_we); end
    n_cmp++; if (obs_addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr got=%h exp=00000200", obs_addr); end
    n_cmp++; if (obs_rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL sb_rdata_kept got=%h exp=ffff80ff", obs_rd); end
    n_cmp++; if (obs_we_done !== 1'b0 || obs_be_done !== 4'b0) begin n_fail++; $display("FAIL sb_done we/be got=%b/%b exp=0/0000", obs_we_done, obs_be_done); end
    run_txn(1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h1234_5678, 32'h0, 0);
    n_cmp++; if (obs_wdata !== 32'h5678_5678 || obs_be !== 4'b1100 || obs_we !== 1'b1) begin n_fail++; $display("FAIL sh_bus got=%h/%b/%b exp=56785678/1100/1", obs_wdata, obs_be, obs_we); end
    // MemWrite wins when both strobes are high.
    run_txn(1'b1, 1'b1, F3_W, 32'h0000_0208, 32'hA5A5_0F0F, 32'h0, 0);
    n_cmp++; if (obs_wdata !== 32'hA5A5_0F0F || obs_be !== 4'b1111 || obs_we !== 1'b1 || obs_addr !== 32'h208) begin n_fail++; $display("FAIL sw_both got=%h/%b/%b/%h exp=a5a50f0f/1111/1/00000208", obs_wdata, obs_be, obs_we, obs_addr); end
    n_cmp++; if (obs_rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL sw_rdata_kept got=%h exp=ffff80ff", obs_rd); end
  endtask

  task automatic test_fault();
    run_fault(1'b1, 1'b0, F3_W, 32'h0000_0101);
    n_cmp++; if (obs_stall_idle !== 1'b0 || obs_req_idle !== 1'b0) begin n_fail++; $display("FAIL mis_idle stall/req got=%b%b exp=00", obs_stall_idle, obs_req_idle); end
    n_cmp++; if (obs_fault_done !== 1'b1 || obs_rd !== 32'h0 || obs_req_done !== 1'b0 || obs_stall_done !== 1'b0) begin n_fail++; $display("FAIL mis_done fault/rd/req/stall got=%b/%h/%b/%b exp=1/00000000/0/0", obs_fault_done, obs_rd, obs_req_done, obs_stall_done); end
    n_cmp++; if (obs_fault_after !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b exp=0", obs_fault_after); end
    run_fault(1'b0, 1'b1, F3_BU, 32'h0000_0200);
    n_cmp++; if (obs_fault_done !== 1'b1 || obs_req_idle !== 1'b0 || obs_stall_idle !== 1'b0) begin n_fail++; $display("FAIL ill_store fault/req/stall got=%b/%b/%b exp=1/0/0", obs_fault_done, obs_req_idle, obs_stall_idle); end
    run_fault(1'b1, 1'b0, 3'b011, 32'h0000_0200);
    n_cmp++; if (obs_fault_done !== 1'b1 || obs_req_idle !== 1'b0) begin n_fail++; $display("FAIL ill_load fault/req got=%b/%b exp=1/0", obs_fault_done, obs_req_idle); end
    run_fault(1'b1, 1'b0, F3_HU, 32'h0000_0103);
    n_cmp++; if (obs_fault_done !== 1'b1) begin n_fail++; $display("FAIL mis_hu fault got=%b exp=1", obs_fault_done); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, 32'h1122_3344, 0);
    n_cmp++; if (obs_rd !== 32'h1122_3344) begin n_fail++; $display("FAIL b2b_first got=%h exp=11223344", obs_rd); end
    run_txn(1'b1, 1'b0, F3_BU, 32'h0000_0011, 32'h0, 32'h1122_3344, 0);
    n_cmp++; if (obs_rd !== 32'h0000_0033 || obs_stall_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_second rd/stall got=%h/%b exp=00000033/1", obs_rd, obs_stall_idle); end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int fault_cnt = 0;
    int fault_k = -1;
    logic [31:0] rd_at_fault = 32'hFFFF_FFFF;
    logic stall_at_done = 1'b1;
    #1;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; ALUResult = 32'h0000_0300; bus.MemReady = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      if (bus.MemReq) req_cnt++;
      if (AccessFault) begin fault_cnt++; fault_k = k; rd_at_fault = ReadData; end
      if (k == TO + 1) stall_at_done = Stall;
      @(posedge CLK); #1;
      if (k == TO) MemRead = 1'b0;
    end
    n_cmp++; if (req_cnt != TO) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=%0d", req_cnt, TO); end
    n_cmp++; if (fault_cnt != 1 || fault_k != TO + 1) begin n_fail++; $display("FAIL to_fault count/cycle got=%0d/%0d exp=1/%0d", fault_cnt, fault_k, TO + 1); end
    n_cmp++; if (rd_at_fault !== 32'h0 || stall_at_done !== 1'b0) begin n_fail++; $display("FAIL to_done rd/stall got=%h/%b exp=00000000/0", rd_at_fault, stall_at_done); end
  endtask

  task automatic test_reset_mid_req();
    #1;
    MemRead = 1'b1; Funct3 = F3_W; ALUResult = 32'h0000_0400; bus.MemReady = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (bus.MemReq !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_req got=%b exp=1", bus.MemReq); end
    #2;
    RST_N = 1'b0; MemRead = 1'b0;
    #1;
    n_cmp++; if (bus.MemReq !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL mrst_async req/stall got=%b/%b exp=0/0", bus.MemReq, Stall); end
    n_cmp++; if (bus.MemAddr !== 32'h0 || bus.MemBE !== 4'b0 || ReadData !== 32'h0) begin n_fail++; $display("FAIL mrst_clear got=%h/%b/%h exp=0/0000/0", bus.MemAddr, bus.MemBE, ReadData); end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++; if ({bus.MemReq, bus.MemWE, AccessFault, Stall} !== 4'b0) begin n_fail++; $display("FAIL mrst_idle got=%b exp=0000", {bus.MemReq, bus.MemWE, AccessFault, Stall}); end
    @(posedge CLK);
    run_txn(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0);
    n_cmp++; if (obs_rd !== 32'hCAFE_F00D || obs_req_cycles != 1 || obs_addr !== 32'h104) begin n_fail++; $display("FAIL mrst_next_lw rd/cycles/addr got=%h/%0d/%h exp=cafef00d/1/00000104", obs_rd, obs_req_cycles, obs_addr); end
  endtask

  initial begin
    bus.MemReady = 1'b0;
    bus.MemRData = 32'h0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the execute datapath.
- Consumes ALUResult as the effective address and RD2 as the store data, and runs one data-memory transaction over a req/ready bus.
- Returns sign- or zero-extended load data as ReadData, which feeds the core's Result writeback mux.
- Asserts Stall so the single-cycle core freezes PC and register writes while a transaction is outstanding.

Parameters:
- D_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, maximum cycles in REQ waiting for MemReady before abort; must be at least 1.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- MemRead  input  1  current instruction is a load.
- MemWrite  input  1  current instruction is a store; wins if MemRead is also high.
- Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  input  D_WIDTH  byte address.
- RD2  input  D_WIDTH  store data.
- MemReady  input  1  memory accepts/completes the request this cycle.
- MemRData  input  D_WIDTH  word read data, valid when MemReady=1.
- MemReq  output  1  request valid (registered).
- MemWE  output  1  1 = write (registered).
- MemAddr  output  D_WIDTH  word-aligned address, ALUResult with bits [1:0] cleared (registered).
- MemWData  output  D_WIDTH  lane-replicated store data (registered).
- MemBE  output  4  byte enables (registered).
- ReadData  output  D_WIDTH  formatted load result (registered).
- Stall  output  1  core must hold (combinational).
- AccessFault  output  1  one-cycle pulse on misalignment, illegal Funct3 or timeout (registered).

Behaviour:
- Reset: state IDLE; MemReq, MemWE, MemAddr, MemWData, MemBE, ReadData, AccessFault and timeout counter all 0.
  - Reset is asynchronous; asserting it mid-transaction drops MemReq immediately.
- Stall = (state==IDLE && access && !fault_now) || state==REQ.
  - access = MemRead|MemWrite.
- Misalignment is checked on ALUResult[1:0]:
  - H/HU with bit0=1 is misaligned.
  - W with [1:0]!=0 is misaligned.
  - B/BU is never misaligned.
- Illegal Funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.
- fault_now = access && (misaligned || illegal).
- FSM:
  - IDLE, access with no fault:
    - Register MemReq=1, MemWE=MemWrite, MemAddr, MemBE, MemWData, and latch Funct3 plus ALUResult[1:0].
    - Clear the counter and go to REQ.
  - IDLE, fault_now: pulse AccessFault next cycle, ReadData<=0, no bus transaction, go to DONE.
  - REQ, MemReady=1:
    - MemReq<=0.
    - For a load, ReadData<=formatted MemRData; for a store, ReadData is unchanged.
    - Go to DONE.
  - REQ, MemReady=0, counter==TIMEOUT-1: MemReq<=0, ReadData<=0, AccessFault pulses, go to DONE.
  - REQ, otherwise: counter+1.
  - DONE: Stall=0; the core commits this cycle; go to IDLE. No new request is started in DONE, even with access high, because it is the same instruction.
- Minimum latency is 3 cycles (IDLE, REQ with MemReady, DONE). The fault path takes 2 cycles.
- Store formatting:
  - SB: WData = {4{RD2[7:0]}}, BE = 4'b0001 << addr[1:0].
  - SH: WData = {2{RD2[15:0]}}, BE = addr[1] ? 1100 : 0011.
  - SW: WData = RD2, BE = 1111.
- Load formatting:
  - Lane = MemRData >> (8*addr[1:0]).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- MemReq, MemAddr, MemBE, MemWData and MemWE stay stable throughout REQ.
- MemBE returns to 0 and MemWE to 0 when leaving REQ.

Decomposition:
- Shared package core_pkg:
  - Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, REQ, DONE}.
- Natural sub-module: lsu_align, a combinational helper that takes Funct3, addr[1:0], RD2 and MemRData and produces WData, BE, load data, misaligned and illegal.

Test Plan:
- LW: addr 0x00000104, MemRData 0xDEADBEEF, MemReady in the first REQ cycle → MemAddr 0x104, BE 1111, ReadData 0xDEADBEEF, Stall high 2 cycles then low in DONE.
- LB vs LBU: addr 0x103, MemRData 0x80FF0000 → LB yields 0xFFFFFF80, LBU yields 0x00000080.
- SB / SH: SB to addr 0x202 with RD2 0x12345678 → WData 0x78787878, BE 0100. SH to 0x202 → WData 0x56785678, BE 1100, MemWE=1.
- Misaligned LW at addr 0x101 → no MemReq ever asserted, AccessFault pulses one cycle, ReadData 0, Stall low in the first cycle.
- Timeout: MemReady held 0, TIMEOUT=4 → MemReq high exactly 4 cycles, then AccessFault pulse, DONE, ReadData 0.
- Reset mid-REQ (RST_N low asynchronously) → MemReq drops the same instant. After release the unit is IDLE with all outputs 0, and the next LW completes normally.
